// File: rtl/watch_pkg.sv
// Shared FSM state type, key codes and the row/column-to-key map
// for the keypad scanner.
package watch_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEB_PRESS,
        HELD,
        DEB_REL
    } state_t;

    localparam logic [3:0] KEY_STAR   = 4'd10;
    localparam logic [3:0] KEY_HASH   = 4'd11;
    localparam int         NUM_DIGITS = 10;

    // Rows 0-2 hold 1-9 in reading order; row 3 is *, 0, #.
    function automatic logic [3:0] key_map(
        input logic [1:0] row,
        input logic [1:0] col
    );
        logic [3:0] code;
        if (row == 2'd3) begin
            case (col)
                2'd0:    code = KEY_STAR;
                2'd1:    code = 4'd0;
                default: code = KEY_HASH;
            endcase
        end else begin
            code = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
        end
        return code;
    endfunction

    function automatic logic single_low(input logic [3:0] row);
        return $countones(~row) == 1;
    endfunction

    function automatic logic [1:0] low_idx(input logic [3:0] row);
        logic [1:0] idx;
        idx = '0;
        for (int i = 3; i >= 0; i--) begin
            if (!row[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic [1:0] col_next(input logic [1:0] col);
        return (col == 2'd2) ? 2'd0 : col + 2'd1;
    endfunction

    function automatic logic [9:0] digit_onehot(input logic [3:0] code);
        logic [9:0] v;
        v = '0;
        if (code < 4'(NUM_DIGITS)) v = 10'b1 << code;
        return v;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Saturating run-length counter shared by the press and release
// debounce phases of the keypad scanner.
module key_debounce
    import watch_pkg::*;
#(
    parameter int DEB_CNT = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic done
);

    localparam int W = $clog2(DEB_CNT + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && cnt != W'(DEB_CNT)) begin
            cnt <= cnt + W'(1);
        end
    end

    assign done = (cnt == W'(DEB_CNT));

endmodule

// File: rtl/keypad_scan.sv
// 4x3 matrix keypad scanner with debounce; optional auto-repeat is
// enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan
    import watch_pkg::*;
#(
    parameter int SCAN_DIV  = 4,
    parameter int DEB_CNT   = 20,
    parameter int REP_DELAY = 500,
    parameter int REP_RATE  = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] kp_row,
    output logic [2:0] kp_col,
    output logic [9:0] key_onehot,
    output logic [3:0] key_code,
    output logic       key_valid
);

    localparam int DIV_W = $clog2(SCAN_DIV);

    // A row sample is only trusted once it was taken with the current
    // column driven, which needs the column stable for two clocks.
    if (SCAN_DIV < 3 || DEB_CNT < 1 || REP_DELAY < 1 || REP_RATE < 1)
    begin : g_param_check
        $error("keypad_scan: need SCAN_DIV >= 3 and counts >= 1");
    end

    state_t           state;
    state_t           state_nx;
    logic [3:0]       row_s1;
    logic [3:0]       row_s2;
    logic [1:0]       col;
    logic [1:0]       col_d1;
    logic [1:0]       col_d2;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       r_lat;
    logic [3:0]       row_lat;
    logic [3:0]       code_nx;

    logic col_ok;
    logic hit;
    logic same;
    logic lat_high;
    logic deb_inc;
    logic deb_clr;
    logic deb_done;
    logic latch;
    logic accept;
    logic release_done;
    logic scan_step;
    logic rep_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_s1 <= '1;
            row_s2 <= '1;
        end else begin
            row_s1 <= kp_row;
            row_s2 <= row_s1;
        end
    end

    assign col_ok   = (col_d1 == col) && (col_d2 == col);
    assign hit      = col_ok && single_low(row_s2);
    assign same     = (row_s2 == row_lat);
    assign lat_high = row_s2[r_lat];
    assign code_nx  = key_map(r_lat, col);
    assign kp_col   = ~(3'b001 << col);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SCAN;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            SCAN: begin
                if (hit) state_nx = DEB_PRESS;
            end
            DEB_PRESS: begin
                if (deb_done)   state_nx = HELD;
                else if (!same) state_nx = SCAN;
            end
            HELD: begin
                if (lat_high) state_nx = DEB_REL;
            end
            DEB_REL: begin
                if (deb_done)       state_nx = SCAN;
                else if (!lat_high) state_nx = HELD;
            end
        endcase
    end

    always_comb begin
        deb_inc      = 1'b0;
        deb_clr      = 1'b0;
        latch        = 1'b0;
        accept       = 1'b0;
        release_done = 1'b0;
        scan_step    = 1'b0;
        unique case (state)
            SCAN: begin
                if (hit) begin
                    latch   = 1'b1;
                    deb_inc = 1'b1;
                end else begin
                    deb_clr   = 1'b1;
                    scan_step = 1'b1;
                end
            end
            DEB_PRESS: begin
                if (deb_done) begin
                    accept  = 1'b1;
                    deb_clr = 1'b1;
                end else if (same) begin
                    deb_inc = 1'b1;
                end else begin
                    deb_clr = 1'b1;
                end
            end
            HELD: begin
                if (lat_high) deb_inc = 1'b1;
                else          deb_clr = 1'b1;
            end
            DEB_REL: begin
                if (deb_done) begin
                    release_done = 1'b1;
                    deb_clr      = 1'b1;
                end else if (lat_high) begin
                    deb_inc = 1'b1;
                end else begin
                    deb_clr = 1'b1;
                end
            end
        endcase
    end

    key_debounce #(
        .DEB_CNT (DEB_CNT)
    ) u_deb (
        .clk  (clk),
        .rst  (rst),
        .inc  (deb_inc),
        .clr  (deb_clr),
        .done (deb_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col     <= '0;
            col_d1  <= '0;
            col_d2  <= '0;
            div_cnt <= '0;
        end else begin
            col_d1 <= col;
            col_d2 <= col_d1;
            if (scan_step) begin
                if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
                    div_cnt <= '0;
                    col     <= col_next(col);
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
            end else begin
                div_cnt <= '0;
                if (release_done) col <= col_next(col);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lat   <= '0;
            row_lat <= '1;
        end else if (latch) begin
            r_lat   <= low_idx(row_s2);
            row_lat <= row_s2;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_MAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] rep_lim;
    logic             rep_first;

    assign rep_lim  = rep_first ? REP_W'(REP_DELAY - 1)
                                : REP_W'(REP_RATE - 1);
    assign rep_fire = (state == HELD) && (rep_cnt == rep_lim);

    // Timer pauses through release bounce so a brief lift keeps cadence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else if (state == HELD) begin
            if (rep_fire) begin
                rep_cnt   <= '0;
                rep_first <= 1'b0;
            end else begin
                rep_cnt <= rep_cnt + REP_W'(1);
            end
        end else if (state != DEB_REL) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_valid  <= 1'b0;
            key_code   <= '0;
            key_onehot <= '0;
        end else begin
            key_valid <= accept | rep_fire;
            if (accept) begin
                key_code   <= code_nx;
                key_onehot <= digit_onehot(code_nx);
            end else if (release_done) begin
                key_onehot <= '0;
            end
        end
    end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter SCAN_DIV, default 4, clk cycles each column is driven before advancing.
REQ-002 Parameter DEB_CNT, default 20, consecutive identical samples required to accept a press or release.
REQ-003 Parameter REP_DELAY, default 500, cycles held before first auto-repeat.
REQ-004 Parameter REP_RATE, default 200, cycles between auto-repeats.
REQ-005 clk  input  1  1 kHz system clock.
REQ-006 rst  input  1  reset; asynchronous, active-high.
REQ-007 kp_row  input  4  matrix row sense, active-low, asynchronous to clk.
REQ-008 kp_col  output  3  matrix column drive, active-low, exactly one bit low at all times.
REQ-009 key_onehot  output  10  bit n high while digit n is accepted and held; zero otherwise.
REQ-010 key_code  output  4  code of the last accepted key: 0-9 digits, 10 '*', 11 '#'.
REQ-011 key_valid  output  1  one-cycle pulse per accepted press (and per repeat when enabled).

Function
REQ-012 kp_row SHALL pass through a two-flop synchronizer before any use; all latencies are counted from the synchronized value.
REQ-013 Key map (row,col): r0 = 1,2,3; r1 = 4,5,6; r2 = 7,8,9; r3 = *,0,#.
REQ-014 FSM states SCAN, DEB_PRESS, HELD, DEB_REL.
REQ-015 SCAN: column index advances 0->1->2->0 every SCAN_DIV cycles; when exactly one synchronized row is low, FSM SHALL latch (row,col), freeze the column and enter DEB_PRESS.
REQ-016 Two or more rows low in SCAN SHALL be ignored; scanning continues.
REQ-017 DEB_PRESS: counter increments while the same single row stays low; at DEB_CNT -> HELD; any change -> counter cleared, return to SCAN with column unchanged.
REQ-018 On entering HELD: key_code updated, key_valid pulses exactly one cycle, key_onehot set to the digit bit (zero for '*'/'#').
REQ-019 HELD: column stays frozen; when latched row goes high -> DEB_REL.
REQ-020 DEB_REL: counter increments while row high; at DEB_CNT -> clear key_onehot, resume SCAN at next column; row low again -> back to HELD with no new pulse.
REQ-021 key_code SHALL hold its value across release; only a new accepted press changes it.
REQ-022 Counters SHALL be sized ceil(log2(max parameter+1)) and SHALL saturate, never wrap.

Reset
REQ-023 During and after rst: state SCAN, column 0 driven (kp_col=3'b110), key_onehot=0, key_code=0, key_valid=0, all counters 0, synchronizer flops 1.
REQ-024 rst asserted mid-debounce or mid-hold SHALL abort without emitting key_valid.

Configuration
REQ-025 Macro KEYPAD_REPEAT_EN defined: in HELD, after REP_DELAY cycles key_valid pulses once, then every REP_RATE cycles until release; key_code unchanged.
REQ-026 Macro KEYPAD_REPEAT_EN undefined: exactly one key_valid per press; REP_DELAY/REP_RATE unused; no repeat counter synthesized.

Structure
REQ-027 Package watch_pkg holds the FSM state typedef, key-code constants (KEY_STAR=10, KEY_HASH=11) and the row/col-to-code map.
REQ-028 Sub-module key_debounce (counter + compare, parameter DEB_CNT) SHALL be instantiated once and shared by press and release phases.

Verification
REQ-029 Reset, no keys -> kp_col cycles 110,101,011 every 4 cycles; key_valid never asserts.
REQ-030 Hold '5' (row1 low when col1 driven) 30 cycles -> one key_valid 2+20 cycles after first low sample, key_code=5, key_onehot=10'b0000100000.
REQ-031 Press '8' with 5-cycle bounce (toggle every cycle) then stable -> exactly one key_valid, key_code=8.
REQ-032 Rows 0 and 2 low together -> no key_valid, scanning continues.
REQ-033 KEYPAD_REPEAT_EN, hold '#' 1000 cycles -> key_valid at ~22, ~522, ~722, ~922; key_code=11, key_onehot=0.
REQ-034 rst asserted at cycle 10 of DEB_PRESS on '3' -> no key_valid, kp_col=3'b110, all outputs zero next cycle.
